// File: rtl/game_pkg.sv
// Shared types, colours and move arithmetic for the player sprite path.
// Build option PLAYER_WRAP_EN: moves that leave the frame wrap to the far edge instead of clamping.
package game_pkg;

   typedef logic [11:0] pixel_t;

   localparam int H_FRAME_DEF = 160;
   localparam int V_FRAME_DEF = 120;

   typedef struct packed {
      logic [$clog2(H_FRAME_DEF)-1:0] x;
      logic [$clog2(V_FRAME_DEF)-1:0] y;
   } player_t;

   localparam pixel_t RED    = 12'hF00;
   localparam pixel_t YELLOW = 12'hFF0;
   localparam pixel_t SKY    = 12'h0FF;
   localparam pixel_t GRASS  = 12'h0F0;

   localparam logic [1:0] MOVE_NONE = 2'b00;
   localparam logic [1:0] MOVE_POS  = 2'b01;
   localparam logic [1:0] MOVE_NEG  = 2'b10;

   typedef enum logic [2:0] {
      ST_INIT,
      ST_IDLE,
      ST_CALC,
      ST_ERASE,
      ST_DRAW
   } state_t;

   // Done in int so pos+step can never overflow the coordinate width.
   function automatic int move_axis(input int pos, input logic [1:0] mv,
                                    input int step, input int limit);
      int res;
      res = pos;
      if (mv == MOVE_POS) begin
`ifdef PLAYER_WRAP_EN
         res = (pos + step >= limit) ? pos + step - limit : pos + step;
`else
         res = (pos + step > limit - 1) ? limit - 1 : pos + step;
`endif
      end else if (mv == MOVE_NEG) begin
`ifdef PLAYER_WRAP_EN
         res = (pos < step) ? pos + limit - step : pos - step;
`else
         res = (pos < step) ? 0 : pos - step;
`endif
      end
      return res;
   endfunction

endpackage

// File: rtl/frame_bg_lut.sv
// Background colour of a frame pixel: sun in the upper right, sky above, grass below.
// Used for both frame init and sprite erase so the two always agree.
module frame_bg_lut
   import game_pkg::*;
#(
   parameter int H_FRAME_HT       = 160,
   parameter int V_FRAME_HT       = 120,
   parameter int GRASS_PERCENTAGE = 25
) (
   input  logic [$clog2(V_FRAME_HT)-1:0] row,
   input  logic [$clog2(H_FRAME_HT)-1:0] col,
   output logic [11:0]                   pixel
);

   // The sun's row bound is scaled from the frame width, not its height.
   localparam int SUN_COL  = H_FRAME_HT * 80 / 100;
   localparam int SUN_ROW  = H_FRAME_HT * 20 / 100;
   localparam int SKY_ROWS = V_FRAME_HT * (100 - GRASS_PERCENTAGE) / 100;

   always_comb begin
      if (int'(col) > SUN_COL && int'(row) < SUN_ROW)
         pixel = YELLOW;
      else if (int'(row) < SKY_ROWS)
         pixel = SKY;
      else
         pixel = GRASS;
   end

endmodule

// File: rtl/player_frame_ctrl.sv
// Per-frame player sprite update: move on frame_tick, then erase old pixel and draw new one.
// Build option PLAYER_WRAP_EN (see game_pkg) selects wrap-around instead of clamped movement.
module player_frame_ctrl
   import game_pkg::*;
#(
   parameter int H_FRAME_HT       = 160,
   parameter int V_FRAME_HT       = 120,
   parameter int GRASS_PERCENTAGE = 25,
   parameter int STEP             = 1
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          frame_tick,
   input  logic [1:0]                    move_x,
   input  logic [1:0]                    move_y,
   output logic [$clog2(H_FRAME_HT)-1:0] player_x,
   output logic [$clog2(V_FRAME_HT)-1:0] player_y,
   output logic                          wr_valid,
   input  logic                          wr_ready,
   output logic [$clog2(V_FRAME_HT)-1:0] wr_row,
   output logic [$clog2(H_FRAME_HT)-1:0] wr_col,
   output logic [11:0]                   wr_pixel,
   output logic                          busy,
   output logic [7:0]                    drop_cnt
);

   localparam int XW = $clog2(H_FRAME_HT);
   localparam int YW = $clog2(V_FRAME_HT);
   localparam logic [XW-1:0] X_HOME = XW'(H_FRAME_HT / 2);
   localparam logic [YW-1:0] Y_HOME = YW'(V_FRAME_HT / 2);

   state_t state, next_state;

   logic [1:0]    move_x_q, move_y_q;
   logic [XW-1:0] old_x, new_x;
   logic [YW-1:0] old_y, new_y;
   logic          wr_fire, moved;
   pixel_t        bg_pixel;

   logic          wr_valid_d;
   logic [YW-1:0] wr_row_d;
   logic [XW-1:0] wr_col_d;
   pixel_t        wr_pixel_d;

   assign wr_fire = wr_valid && wr_ready;
   assign new_x   = XW'(move_axis(int'(old_x), move_x_q, STEP, H_FRAME_HT));
   assign new_y   = YW'(move_axis(int'(old_y), move_y_q, STEP, V_FRAME_HT));
   assign moved   = (new_x != old_x) || (new_y != old_y);
   assign busy    = (state != ST_IDLE);

   frame_bg_lut #(
      .H_FRAME_HT      (H_FRAME_HT),
      .V_FRAME_HT      (V_FRAME_HT),
      .GRASS_PERCENTAGE(GRASS_PERCENTAGE)
   ) u_bg (
      .row  (old_y),
      .col  (old_x),
      .pixel(bg_pixel)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state <= ST_INIT;
      else
         state <= next_state;
   end

   always_comb begin
      next_state = state;
      case (state)
         ST_INIT:  if (wr_fire) next_state = ST_IDLE;
         ST_IDLE:  if (frame_tick) next_state = ST_CALC;
         ST_CALC:  next_state = moved ? ST_ERASE : ST_IDLE;
         ST_ERASE: if (wr_fire) next_state = ST_DRAW;
         ST_DRAW:  if (wr_fire) next_state = ST_IDLE;
         default:  next_state = ST_INIT;
      endcase
   end

   // Write port is registered, so its next value is decoded from the state being entered.
   always_comb begin
      wr_valid_d = 1'b0;
      wr_row_d   = wr_row;
      wr_col_d   = wr_col;
      wr_pixel_d = wr_pixel;
      case (next_state)
         ST_INIT: begin
            wr_valid_d = 1'b1;
            wr_row_d   = player_y;
            wr_col_d   = player_x;
            wr_pixel_d = RED;
         end
         ST_ERASE: begin
            wr_valid_d = 1'b1;
            wr_row_d   = old_y;
            wr_col_d   = old_x;
            wr_pixel_d = bg_pixel;
         end
         ST_DRAW: begin
            wr_valid_d = 1'b1;
            wr_row_d   = player_y;
            wr_col_d   = player_x;
            wr_pixel_d = RED;
         end
         default: ;
      endcase
   end

   // Position, latched request and drop counter; ticks outside IDLE are only counted.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         player_x <= X_HOME;
         player_y <= Y_HOME;
         old_x    <= '0;
         old_y    <= '0;
         move_x_q <= MOVE_NONE;
         move_y_q <= MOVE_NONE;
         wr_valid <= 1'b0;
         wr_row   <= '0;
         wr_col   <= '0;
         wr_pixel <= '0;
         drop_cnt <= '0;
      end else begin
         wr_valid <= wr_valid_d;
         wr_row   <= wr_row_d;
         wr_col   <= wr_col_d;
         wr_pixel <= wr_pixel_d;
         if (state == ST_IDLE && frame_tick) begin
            move_x_q <= move_x;
            move_y_q <= move_y;
            old_x    <= player_x;
            old_y    <= player_y;
         end
         if (state == ST_CALC && moved) begin
            player_x <= new_x;
            player_y <= new_y;
         end
         if (frame_tick && state != ST_IDLE && drop_cnt != 8'hFF)
            drop_cnt <= drop_cnt + 8'd1;
      end
   end

endmodule

// File: tb/tb_player_frame_ctrl.sv
// Directed bench for player_frame_ctrl: vector table for basic moves plus hand sequences
// for bounds, background colours, stalls, dropped ticks and mid-sequence reset.
module tb_player_frame_ctrl;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       frame_tick = 1'b0;
   logic [1:0] move_x = 2'b00;
   logic [1:0] move_y = 2'b00;
   logic       wr_ready = 1'b1;
   logic [7:0] player_x;
   logic [6:0] player_y;
   logic       wr_valid;
   logic [6:0] wr_row;
   logic [7:0] wr_col;
   logic [11:0] wr_pixel;
   logic       busy;
   logic [7:0] drop_cnt;

   int errors = 0;
   int checks = 0;
   int q_row[$];
   int q_col[$];
   int q_pix[$];
   int q_px[$];
   int busy_cycles;

   typedef struct {
      logic [1:0] mx;
      logic [1:0] my;
      int n_wr;
      int e_row;
      int e_col;
      int e_pix;
      int d_row;
      int d_col;
      int px;
      int py;
   } vec_t;

   vec_t vecs[5];

   player_frame_ctrl dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .frame_tick(frame_tick),
      .move_x    (move_x),
      .move_y    (move_y),
      .player_x  (player_x),
      .player_y  (player_y),
      .wr_valid  (wr_valid),
      .wr_ready  (wr_ready),
      .wr_row    (wr_row),
      .wr_col    (wr_col),
      .wr_pixel  (wr_pixel),
      .busy      (busy),
      .drop_cnt  (drop_cnt)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input int actual, input int expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
      end
   endtask

   // Called on a falling edge; records every accepted write until the block is idle again.
   task automatic collectWrites();
      int n;
      n = 0;
      q_row.delete();
      q_col.delete();
      q_pix.delete();
      q_px.delete();
      while (busy && n < 40) begin
         if (wr_valid && wr_ready) begin
            q_row.push_back(int'(wr_row));
            q_col.push_back(int'(wr_col));
            q_pix.push_back(int'(wr_pixel));
            q_px.push_back(int'(player_x));
         end
         n++;
         @(negedge clk);
      end
      busy_cycles = n;
      if (busy) checkOutput("seq_timeout", int'(busy), 0);
   endtask

   task automatic applyStimulus(input logic [1:0] mx, input logic [1:0] my);
      frame_tick = 1'b1;
      move_x     = mx;
      move_y     = my;
      @(negedge clk);
      frame_tick = 1'b0;
      move_x     = 2'b00;
      move_y     = 2'b00;
      collectWrites();
   endtask

   task automatic travel(input logic [1:0] mx, input logic [1:0] my, input int count);
      repeat (count) applyStimulus(mx, my);
   endtask

   task automatic checkMove(input string tag, input int n, input int er, input int ec,
                            input int ep, input int dr, input int dc, input int px, input int py);
      checkOutput({tag, "_nwr"}, q_row.size(), n);
      if (n == 2 && q_row.size() == 2) begin
         checkOutput({tag, "_erase_row"}, q_row[0], er);
         checkOutput({tag, "_erase_col"}, q_col[0], ec);
         checkOutput({tag, "_erase_pix"}, q_pix[0], ep);
         checkOutput({tag, "_draw_row"}, q_row[1], dr);
         checkOutput({tag, "_draw_col"}, q_col[1], dc);
         checkOutput({tag, "_draw_pix"}, q_pix[1], 'hF00);
         checkOutput({tag, "_px_at_erase"}, q_px[0], px);
      end
      checkOutput({tag, "_player_x"}, int'(player_x), px);
      checkOutput({tag, "_player_y"}, int'(player_y), py);
   endtask

   initial begin
      #1_000_000;
      $display("[TB] FAIL watchdog: got timeout expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      vecs[0] = '{2'b01, 2'b00, 2, 60, 80, 'h0FF, 60, 81, 81, 60};
      vecs[1] = '{2'b00, 2'b01, 2, 60, 81, 'h0FF, 61, 81, 81, 61};
      vecs[2] = '{2'b10, 2'b10, 2, 61, 81, 'h0FF, 60, 80, 80, 60};
      vecs[3] = '{2'b11, 2'b11, 0, 0, 0, 0, 0, 0, 80, 60};
      vecs[4] = '{2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 80, 60};

      repeat (2) @(negedge clk);
      checkOutput("rst_wr_valid", int'(wr_valid), 0);
      checkOutput("rst_busy", int'(busy), 1);
      checkOutput("rst_player_x", int'(player_x), 80);
      checkOutput("rst_player_y", int'(player_y), 60);
      checkOutput("rst_drop_cnt", int'(drop_cnt), 0);
      checkOutput("rst_wr_pixel", int'(wr_pixel), 0);

      rst_n = 1'b1;
      collectWrites();
      checkOutput("init_nwr", q_row.size(), 1);
      if (q_row.size() == 1) begin
         checkOutput("init_row", q_row[0], 60);
         checkOutput("init_col", q_col[0], 80);
         checkOutput("init_pix", q_pix[0], 'hF00);
      end
      checkOutput("init_busy", int'(busy), 0);

      for (int i = 0; i < 5; i++) begin
         applyStimulus(vecs[i].mx, vecs[i].my);
         checkMove($sformatf("vec%0d", i), vecs[i].n_wr, vecs[i].e_row, vecs[i].e_col,
                   vecs[i].e_pix, vecs[i].d_row, vecs[i].d_col, vecs[i].px, vecs[i].py);
      end

      travel(2'b01, 2'b00, 79);
      checkOutput("right_edge_x", int'(player_x), 159);
      applyStimulus(2'b01, 2'b00);
`ifdef PLAYER_WRAP_EN
      checkMove("wrap_right", 2, 60, 159, 'h0FF, 60, 0, 0, 60);
      applyStimulus(2'b10, 2'b00);
      checkOutput("wrap_back_x", int'(player_x), 159);
`else
      checkMove("clamp_right", 0, 0, 0, 0, 0, 0, 159, 60);
      checkOutput("clamp_right_busy_cycles", busy_cycles, 1);
`endif

      travel(2'b10, 2'b10, 29);
      travel(2'b00, 2'b10, 21);
      applyStimulus(2'b00, 2'b01);
      checkMove("sun_erase", 2, 10, 130, 'hFF0, 11, 130, 130, 11);

      travel(2'b10, 2'b01, 84);
      travel(2'b10, 2'b00, 36);
      applyStimulus(2'b01, 2'b00);
      checkMove("grass_erase", 2, 95, 10, 'h0F0, 95, 11, 11, 95);

      travel(2'b10, 2'b00, 11);
      applyStimulus(2'b10, 2'b00);
`ifdef PLAYER_WRAP_EN
      checkMove("wrap_left", 2, 95, 0, 'h0F0, 95, 159, 159, 95);
      applyStimulus(2'b01, 2'b00);
`else
      checkMove("clamp_left", 0, 0, 0, 0, 0, 0, 0, 95);
`endif
      checkOutput("pre_stall_drop", int'(drop_cnt), 0);

      // Stalled erase with ticks arriving in CALC and ERASE.
      wr_ready   = 1'b0;
      frame_tick = 1'b1;
      move_x     = 2'b01;
      @(negedge clk);
      move_x = 2'b00;
      @(negedge clk);
      frame_tick = 1'b0;
      for (int i = 0; i < 5; i++) begin
         checkOutput($sformatf("stall%0d_valid", i), int'(wr_valid), 1);
         checkOutput($sformatf("stall%0d_row", i), int'(wr_row), 95);
         checkOutput($sformatf("stall%0d_col", i), int'(wr_col), 0);
         checkOutput($sformatf("stall%0d_pix", i), int'(wr_pixel), 'h0F0);
         frame_tick = (i == 1 || i == 3);
         @(negedge clk);
      end
      frame_tick = 1'b0;
      checkOutput("drop_cnt_3", int'(drop_cnt), 3);
      checkOutput("stall_player_x", int'(player_x), 1);

      frame_tick = 1'b1;
      repeat (300) @(negedge clk);
      frame_tick = 1'b0;
      checkOutput("drop_cnt_sat", int'(drop_cnt), 255);
      checkOutput("long_stall_valid", int'(wr_valid), 1);
      checkOutput("long_stall_row", int'(wr_row), 95);

      wr_ready = 1'b1;
      @(negedge clk);
      wr_ready = 1'b0;
      checkOutput("draw_valid", int'(wr_valid), 1);
      checkOutput("draw_row", int'(wr_row), 95);
      checkOutput("draw_col", int'(wr_col), 1);
      checkOutput("draw_pix", int'(wr_pixel), 'hF00);
      @(negedge clk);

      // Reset while the draw is stalled; outputs must drop without a clock edge.
      #2 rst_n = 1'b0;
      #1;
      checkOutput("midrst_valid", int'(wr_valid), 0);
      checkOutput("midrst_player_x", int'(player_x), 80);
      checkOutput("midrst_player_y", int'(player_y), 60);
      checkOutput("midrst_drop", int'(drop_cnt), 0);
      checkOutput("midrst_busy", int'(busy), 1);
      @(negedge clk);
      rst_n    = 1'b1;
      wr_ready = 1'b1;
      collectWrites();
      checkOutput("reinit_nwr", q_row.size(), 1);
      if (q_row.size() == 1) begin
         checkOutput("reinit_row", q_row[0], 60);
         checkOutput("reinit_col", q_col[0], 80);
         checkOutput("reinit_pix", q_pix[0], 'hF00);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
